imem_fetch_ctrl: RTL and testbench

Fetch sequencer that owns the program counter and drives the word-addressed instruction memory (byte address in, word = addr/4). It waits out a fixed, parameterised memory latency and presents each fetched instruction to decode through a valid/ready handshake. It also accepts branch/jump redirects and flags fetches beyond the populated memory. It sits between the instruction memory and the decode stage, replacing the free-running PC adder for multi-cycle operation.

---
 rtl/imem_fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Multi-cycle instruction fetch sequencer: owns the PC, waits out a fixed memory
// latency, hands each word to decode over valid/ready, and handles redirects and out-of-range fetches.
module imem_fetch_ctrl #(
    parameter int unsigned MEM_LAT   = 2,
    parameter int unsigned MEM_WORDS = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_instr_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        oob_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [31:0] MEM_BYTES    = 32'(MEM_WORDS * 32'd4);
    localparam logic [2:0]  LAT_LAST     = 3'(MEM_LAT - 32'd1);
    localparam bit          SINGLE_CYCLE = (MEM_LAT == 32'd1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_o_q, pc_o_d;
    logic        valid_q, valid_d;
    logic        oob_q, oob_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;

    logic [31:0] redir_pc_s;
    logic [31:0] launch_pc_s;
    logic        redirect_act_s;
    logic        capture_s;
    logic        launch_s;
    logic        launch_oob_s;

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            mem_addr_q <= RESET_PC;
            instr_q    <= 32'd0;
            pc_o_q     <= 32'd0;
            valid_q    <= 1'b0;
            oob_q      <= 1'b0;
            lat_cnt_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
            pc_o_q     <= pc_o_d;
            valid_q    <= valid_d;
            oob_q      <= oob_d;
            lat_cnt_q  <= lat_cnt_d;
        end
    end

    // Event decode: redirect, capture and the start of a new fetch (with its bounds check)
    always_comb begin
        redir_pc_s     = redirect_pc_i & 32'hFFFF_FFFC;
        redirect_act_s = redirect_i && (state_q != ST_IDLE);
        case (state_q)
            ST_ISSUE: capture_s = SINGLE_CYCLE;
            ST_WAIT:  capture_s = (lat_cnt_q == LAT_LAST);
            default:  capture_s = 1'b0;
        endcase
        case (state_q)
            ST_IDLE: launch_s = start_i && !redirect_i;
            ST_HOLD: launch_s = redirect_i || (valid_q && ready_i);
            default: launch_s = redirect_act_s;
        endcase
        launch_pc_s  = redirect_act_s ? redir_pc_s : pc_q;
        launch_oob_s = (launch_pc_s >= MEM_BYTES);
    end

    // Next-state logic; any launch re-evaluates the bounds check
    always_comb begin
        state_d = state_q;
        if (launch_s) begin
            state_d = launch_oob_s ? ST_FAULT : ST_ISSUE;
        end else begin
            case (state_q)
                ST_ISSUE: state_d = capture_s ? ST_HOLD : ST_WAIT;
                ST_WAIT:  state_d = capture_s ? ST_HOLD : ST_WAIT;
                default:  state_d = state_q;
            endcase
        end
    end

    // Datapath next values; a redirect overrides a same-cycle capture or handshake
    always_comb begin
        pc_d       = redirect_i ? redir_pc_s : (capture_s ? pc_q + 32'd4 : pc_q);
        mem_addr_d = (launch_s && !launch_oob_s) ? launch_pc_s : mem_addr_q;
        instr_d    = instr_q;
        pc_o_d     = pc_o_q;
        valid_d    = valid_q;
        lat_cnt_d  = 3'd0;
        if (redirect_act_s) begin
            valid_d = 1'b0;
        end else if (capture_s) begin
            instr_d = mem_instr_i;
            pc_o_d  = mem_addr_q;
            valid_d = 1'b1;
        end else if (launch_s) begin
            valid_d = 1'b0;
        end else begin
            if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) begin
                lat_cnt_d = lat_cnt_q + 3'd1;
            end else begin
                lat_cnt_d = 3'd0;
            end
        end
        oob_d = (state_d == ST_FAULT);
    end

    assign mem_addr_o = mem_addr_q;
    assign instr_o    = instr_q;
    assign pc_o       = pc_o_q;
    assign valid_o    = valid_q;
    assign oob_o      = oob_q;
    assign busy_o     = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_HOLD);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: three instances (MEM_LAT 2, 1, 7) share stimulus; each is
// compared every cycle with a fetch-level model, plus directed literal expectations on the LAT=2 unit.
module tb_imem_fetch_ctrl;

    localparam int NI        = 3;
    localparam int MEM_WORDS = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, redirect = 1'b0, ready = 1'b1;
    logic [31:0] rpc = 32'd0;

    logic [NI-1:0][31:0] mem_addr, mem_instr, instr, pco;
    logic [NI-1:0]       valid, oob, busy;

    logic [31:0] mem [MEM_WORDS];
    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.MEM_LAT(2), .MEM_WORDS(32), .RESET_PC(32'h0)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .redirect_i(redirect), .redirect_pc_i(rpc),
        .mem_addr_o(mem_addr[0]), .mem_instr_i(mem_instr[0]), .instr_o(instr[0]), .pc_o(pco[0]),
        .valid_o(valid[0]), .ready_i(ready), .oob_o(oob[0]), .busy_o(busy[0]));
    imem_fetch_ctrl #(.MEM_LAT(1), .MEM_WORDS(32), .RESET_PC(32'h0)) u_lat1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .redirect_i(redirect), .redirect_pc_i(rpc),
        .mem_addr_o(mem_addr[1]), .mem_instr_i(mem_instr[1]), .instr_o(instr[1]), .pc_o(pco[1]),
        .valid_o(valid[1]), .ready_i(ready), .oob_o(oob[1]), .busy_o(busy[1]));
    imem_fetch_ctrl #(.MEM_LAT(7), .MEM_WORDS(32), .RESET_PC(32'h0)) u_lat7 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .redirect_i(redirect), .redirect_pc_i(rpc),
        .mem_addr_o(mem_addr[2]), .mem_instr_i(mem_instr[2]), .instr_o(instr[2]), .pc_o(pco[2]),
        .valid_o(valid[2]), .ready_i(ready), .oob_o(oob[2]), .busy_o(busy[2]));

    function automatic int lat_of(int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 7;
        endcase
    endfunction

    function automatic void chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[lat=%0d] got=%h want=%h at %0t", name, lat_of(k), act, exp, $time);
        end
    endfunction

    // Memory: returns the addressed word only once the address has been stable long enough
    int          age [NI];
    logic [31:0] last_addr [NI];
    initial for (int k = 0; k < NI; k++) begin age[k] = 0; last_addr[k] = 32'd0; end
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (mem_addr[k] !== last_addr[k]) begin
                age[k] = 0;
                last_addr[k] = mem_addr[k];
            end else if (age[k] < 100) begin
                age[k]++;
            end
            mem_instr[k] = (age[k] >= lat_of(k) - 1) ? mem[mem_addr[k][6:2]]
                                                      : {16'hBAD0, 16'($urandom)};
        end
    end

    // Fetch-level model: a fetch in flight for t cycles delivers when t reaches MEM_LAT
    bit          m_fetch [NI], m_hold [NI], m_fault [NI], m_valid [NI];
    int          m_t [NI];
    logic [31:0] m_pc [NI], m_addr [NI], m_instr [NI], m_pco [NI];

    function automatic void launch(int k, logic [31:0] a);
        if (a >= 32'(4 * MEM_WORDS)) begin
            m_fault[k] = 1'b1;
            m_fetch[k] = 1'b0;
        end else begin
            m_fault[k] = 1'b0;
            m_fetch[k] = 1'b1;
            m_t[k]     = 1;
            m_addr[k]  = a;
        end
    endfunction

    function automatic void model_step(int k);
        logic [31:0] tgt;
        tgt = rpc & 32'hFFFF_FFFC;
        if (!(m_fetch[k] || m_hold[k] || m_fault[k])) begin
            if (redirect) m_pc[k] = tgt;
            else if (start) launch(k, m_pc[k]);
        end else if (redirect) begin
            m_valid[k] = 1'b0;
            m_hold[k]  = 1'b0;
            m_fetch[k] = 1'b0;
            m_fault[k] = 1'b0;
            m_pc[k]    = tgt;
            launch(k, tgt);
        end else if (m_fetch[k]) begin
            if (m_t[k] == lat_of(k)) begin
                m_instr[k] = mem[m_addr[k][6:2]];
                m_pco[k]   = m_addr[k];
                m_valid[k] = 1'b1;
                m_pc[k]    = m_pc[k] + 32'd4;
                m_fetch[k] = 1'b0;
                m_hold[k]  = 1'b1;
            end else begin
                m_t[k]++;
            end
        end else if (m_hold[k] && ready) begin
            m_valid[k] = 1'b0;
            m_hold[k]  = 1'b0;
            launch(k, m_pc[k]);
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                m_fetch[k] = 1'b0; m_hold[k] = 1'b0; m_fault[k] = 1'b0; m_valid[k] = 1'b0;
                m_t[k] = 0; m_pc[k] = 32'd0; m_addr[k] = 32'd0; m_instr[k] = 32'd0; m_pco[k] = 32'd0;
            end else begin
                model_step(k);
            end
        end
    end

    // Per-cycle comparison of every instance against the model
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            chk("mem_addr", k, mem_addr[k], m_addr[k]);
            chk("valid",    k, 32'(valid[k]), 32'(m_valid[k]));
            chk("oob",      k, 32'(oob[k]), 32'(m_fault[k]));
            chk("busy",     k, 32'(busy[k]), 32'(m_fetch[k] || m_hold[k]));
            chk("instr",    k, instr[k], m_instr[k]);
            chk("pc_o",     k, pco[k], m_pco[k]);
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0; redirect = 1'b0; ready = 1'b1; rpc = 32'd0;
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    int  first_v [NI];
    int  n;
    bit  seen;

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'hA000_0000 + 32'(i);
        do_reset();

        // Reset values
        chk("rst_mem_addr", 0, mem_addr[0], 32'h0);
        chk("rst_valid",    0, 32'(valid[0]), 32'h0);
        chk("rst_busy",     0, 32'(busy[0]), 32'h0);
        chk("rst_instr",    0, instr[0], 32'h0);

        // Streaming with ready high: first-valid timing per latency, A0 then A1
        for (int k = 0; k < NI; k++) first_v[k] = 0;
        start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            start = 1'b0;
            for (int k = 0; k < NI; k++) if (valid[k] && first_v[k] == 0) first_v[k] = i;
            if (i == 3) begin
                chk("first_pc", 0, pco[0], 32'h0);
                chk("first_instr", 0, instr[0], 32'hA000_0000);
            end
            if (i == 6) begin
                chk("second_valid", 0, 32'(valid[0]), 32'h1);
                chk("second_pc", 0, pco[0], 32'h4);
                chk("second_instr", 0, instr[0], 32'hA000_0001);
            end
            if (i == 7) chk("third_addr", 0, mem_addr[0], 32'h8);
        end
        chk("first_valid_cycle", 0, 32'(first_v[0]), 32'd3);
        chk("first_valid_cycle", 1, 32'(first_v[1]), 32'd2);
        chk("first_valid_cycle", 2, 32'(first_v[2]), 32'd8);

        // Backpressure: hold A0 for five cycles, then A1 is fetched
        do_reset();
        ready = 1'b0;
        start = 1'b1;
        cyc(); start = 1'b0;
        cyc(); cyc();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 0, 32'(valid[0]), 32'h1);
            chk("bp_instr", 0, instr[0], 32'hA000_0000);
            chk("bp_addr",  0, mem_addr[0], 32'h0);
            cyc();
        end
        ready = 1'b1;
        cyc();
        chk("bp_next_addr", 0, mem_addr[0], 32'h4);
        chk("bp_dropped", 0, 32'(valid[0]), 32'h0);

        // Redirect to 0x12 while the first fetch is in WAIT
        do_reset();
        start = 1'b1;
        cyc(); start = 1'b0;
        cyc();
        redirect = 1'b1; rpc = 32'h0000_0012;
        cyc(); redirect = 1'b0;
        chk("rd_addr",  0, mem_addr[0], 32'h10);
        chk("rd_valid", 0, 32'(valid[0]), 32'h0);
        cyc();
        chk("rd_valid2", 0, 32'(valid[0]), 32'h0);
        cyc();
        chk("rd_deliver", 0, 32'(valid[0]), 32'h1);
        chk("rd_pc",      0, pco[0], 32'h10);
        chk("rd_instr",   0, instr[0], 32'hA000_0004);

        // Sequential run off the end of memory, then recover with a redirect
        do_reset();
        start = 1'b1;
        cyc(); start = 1'b0;
        n = 0;
        while (!oob[0] && n < 400) begin cyc(); n++; end
        chk("fault_reached", 0, 32'(oob[0]), 32'h1);
        chk("fault_busy",    0, 32'(busy[0]), 32'h0);
        chk("fault_valid",   0, 32'(valid[0]), 32'h0);
        chk("fault_addr",    0, mem_addr[0], 32'h7C);
        while (!oob[2] && n < 800) begin cyc(); n++; end
        start = 1'b1;
        cyc(); start = 1'b0;
        chk("fault_sticky", 0, 32'(oob[0]), 32'h1);
        redirect = 1'b1; rpc = 32'h4;
        cyc(); redirect = 1'b0;
        chk("fault_clear", 0, 32'(oob[0]), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin cyc(); seen = valid[0]; end
        chk("fault_recover_seen", 0, 32'(seen), 32'h1);
        chk("fault_recover_pc",   0, pco[0], 32'h4);
        chk("fault_recover_instr", 0, instr[0], 32'hA000_0001);

        // Reset mid-HOLD (second word held) and mid-WAIT
        do_reset();
        start = 1'b1;
        cyc(); start = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        ready = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        chk("rst_hold_valid", 0, 32'(valid[0]), 32'h0);
        chk("rst_hold_addr",  0, mem_addr[0], 32'h0);
        chk("rst_hold_busy",  0, 32'(busy[0]), 32'h0);
        cyc(); rst = 1'b0; ready = 1'b1;
        cyc(); cyc(); cyc();
        chk("idle_no_fetch", 0, 32'(busy[0]), 32'h0);
        start = 1'b1;
        cyc(); start = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        chk("rst_wait_busy", 0, 32'(busy[0]), 32'h0);
        cyc(); rst = 1'b0;
        cyc();

        // Redirect and valid&ready in the same cycle: redirect wins, no word 1 delivery
        start = 1'b1;
        cyc(); start = 1'b0;
        cyc(); cyc();
        chk("rv_held", 0, 32'(valid[0]), 32'h1);
        redirect = 1'b1; rpc = 32'h20;
        cyc(); redirect = 1'b0;
        chk("rv_addr",  0, mem_addr[0], 32'h20);
        chk("rv_valid", 0, 32'(valid[0]), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin cyc(); seen = valid[0]; end
        chk("rv_pc", 0, pco[0], 32'h20);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 7) == 0);
            redirect = ($urandom_range(0, 11) == 0);
            rpc      = 32'($urandom_range(0, 160));
            ready    = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 599) == 0);
            cyc();
            rst = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
